cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result FIFOs feeding one registered common-data-bus broadcast per cycle.
// Round-robin arbitration by default; define CDB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module cdb_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int BUF_DEPTH  = 2,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     flush,
  input  logic [NUM_UNITS-1:0]                     i_valid,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]           i_tag,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]          i_data,
  output logic [NUM_UNITS-1:0]                     o_ready,
  output logic                                     cdb_valid,
  output logic [TAG_WIDTH-1:0]                     cdb_tag,
  output logic [DATA_WIDTH-1:0]                    cdb_data,
  output logic [$clog2(NUM_UNITS*BUF_DEPTH+1)-1:0] o_pending
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int UW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(NUM_UNITS*BUF_DEPTH+1);

  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_UNITS][BUF_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [NUM_UNITS][BUF_DEPTH];
  logic [PW:0]           wr_ptr   [NUM_UNITS];
  logic [PW:0]           rd_ptr   [NUM_UNITS];

  logic [NUM_UNITS-1:0]  empty;
  logic [NUM_UNITS-1:0]  full;
  logic [NUM_UNITS-1:0]  push;
  logic [NUM_UNITS-1:0]  pop;
  logic                  grant_valid;
  logic [UW-1:0]         grant_idx;
  logic [CW-1:0]         push_cnt;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic [DATA_WIDTH-1:0] head_data;

  // Full when the index bits match but the wrap bits differ.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      empty[k] = (wr_ptr[k] == rd_ptr[k]);
      full[k]  = (wr_ptr[k][PW] != rd_ptr[k][PW]) &&
                 (wr_ptr[k][PW-1:0] == rd_ptr[k][PW-1:0]);
    end
  end

  assign o_ready = {NUM_UNITS{i_rst_n}} & ~full;
  assign push    = i_valid & o_ready;

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_UNITS-1; i >= 0; i--) begin
      if (!empty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = UW'(i);
      end
    end
  end
`else
  logic [UW-1:0] rr_ptr;
  logic          hi_valid;
  logic [UW-1:0] hi_idx;
  logic [UW-1:0] lo_idx;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    grant_valid = 1'b0;
    hi_valid    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    for (int i = NUM_UNITS-1; i >= 0; i--) begin
      if (!empty[i]) begin
        grant_valid = 1'b1;
        lo_idx      = UW'(i);
        if (UW'(i) >= rr_ptr) begin
          hi_valid = 1'b1;
          hi_idx   = UW'(i);
        end
      end
    end
    grant_idx = hi_valid ? hi_idx : lo_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == UW'(NUM_UNITS-1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_comb begin
    pop      = '0;
    push_cnt = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      pop[k]   = grant_valid && (grant_idx == UW'(k));
      push_cnt = push_cnt + CW'(push[k]);
    end
  end

  assign head_tag  = tag_mem[grant_idx][rd_ptr[grant_idx][PW-1:0]];
  assign head_data = data_mem[grant_idx][rd_ptr[grant_idx][PW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (push[k] && !flush) begin
        tag_mem[k][wr_ptr[k][PW-1:0]]  <= i_tag[k*TAG_WIDTH +: TAG_WIDTH];
        data_mem[k][wr_ptr[k][PW-1:0]] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Tag and data keep their last broadcast value on idle cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      o_pending <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      o_pending <= '0;
    end else begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_tag  <= head_tag;
        cdb_data <= head_data;
      end
      o_pending <= o_pending + push_cnt - CW'(grant_valid);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, corner-case sequences and randomized traffic
// checked against a queue-based reference model of the result bus.
module tb_cdb_arbiter;

  localparam int NU    = 4;
  localparam int DEPTH = 2;
  localparam int TW    = 6;
  localparam int DW    = 32;
  localparam int CW    = $clog2(NU*DEPTH+1);
`ifdef CDB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NU-1:0]     i_valid;
  logic [NU*TW-1:0]  i_tag;
  logic [NU*DW-1:0]  i_data;
  logic [NU-1:0]     o_ready;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [CW-1:0]     o_pending;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_UNITS(NU), .BUF_DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .flush(flush), .i_valid(i_valid), .i_tag(i_tag),
    .i_data(i_data), .o_ready(o_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .o_pending(o_pending)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NU-1:0]    valid;
    logic [NU*TW-1:0] tag;
    logic [NU*DW-1:0] data;
    logic             flush;
    logic             exp_valid;
    logic [TW-1:0]    exp_tag;
    logic [DW-1:0]    exp_data;
    logic [NU-1:0]    exp_ready;
    logic [CW-1:0]    exp_pending;
  } vec_t;

  vec_t vecs [18];

  // Reference model: one queue of outstanding results in arrival order, tagged with their unit.
  typedef struct packed {
    logic [7:0]    unit;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq [$];
  int            rr = 0;
  logic          exp_v;
  logic [TW-1:0] exp_tag;
  logic [DW-1:0] exp_data;
  logic [NU-1:0] drv_valid = '0;
  logic [TW-1:0] drv_tag  [NU];
  logic [DW-1:0] drv_data [NU];
  logic [NU-1:0] acc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int t);
    return 32'hC0DE_0000 | 32'(t);
  endfunction

  function automatic vec_t mk(input logic [NU-1:0] v, input int t0, input int t1, input int t2,
                              input int t3, input logic fl, input logic ev, input int et,
                              input logic [DW-1:0] ed, input logic [NU-1:0] er, input int ep);
    vec_t r;
    int   t [4];
    t = '{t0, t1, t2, t3};
    r.valid = v;
    r.flush = fl;
    for (int k = 0; k < NU; k++) begin
      r.tag[k*TW +: TW]  = TW'(t[k]);
      r.data[k*DW +: DW] = dat(t[k]);
    end
    r.exp_valid   = ev;
    r.exp_tag     = TW'(et);
    r.exp_data    = ed;
    r.exp_ready   = er;
    r.exp_pending = CW'(ep);
    return r;
  endfunction

  function automatic int cnt(input int k);
    int n = 0;
    foreach (mq[i]) if (mq[i].unit == 8'(k)) n++;
    return n;
  endfunction

  task automatic pushNew(input int k);
    if (!drv_valid[k]) begin
      drv_valid[k] = 1'b1;
      drv_tag[k]   = TW'($urandom);
      drv_data[k]  = $urandom;
    end
  endtask

  // Drive one cycle from drv_*, predict the edge with the model, then check at the falling edge.
  task automatic applyStimulus(input logic fl, output logic [NU-1:0] accepted);
    logic [NU-1:0] rdy;
    int            win;
    flush = fl;
    for (int k = 0; k < NU; k++) begin
      i_valid[k]         = drv_valid[k];
      i_tag[k*TW +: TW]  = drv_tag[k];
      i_data[k*DW +: DW] = drv_data[k];
      rdy[k]             = (cnt(k) < DEPTH);
    end
    #1;
    checkOutput("o_ready", 64'(o_ready), 64'(rdy));
    accepted = drv_valid & rdy;
    exp_v    = 1'b0;
    win      = -1;
    if (fl) begin
      mq.delete();
      rr = 0;
    end else begin
      for (int i = 0; i < NU; i++) begin
        int u;
        u = FIXED ? i : (rr + i) % NU;
        if (win < 0 && cnt(u) > 0) win = u;
      end
      if (win >= 0) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].unit == 8'(win)) begin
            exp_tag  = mq[i].tag;
            exp_data = mq[i].data;
            mq.delete(i);
            break;
          end
        end
        exp_v = 1'b1;
        if (!FIXED) rr = (win + 1) % NU;
      end
      for (int k = 0; k < NU; k++)
        if (accepted[k]) mq.push_back('{unit: 8'(k), tag: drv_tag[k], data: drv_data[k]});
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("cdb_valid", 64'(cdb_valid), 64'(exp_v));
    if (exp_v) begin
      checkOutput("cdb_tag", 64'(cdb_tag), 64'(exp_tag));
      checkOutput("cdb_data", 64'(cdb_data), 64'(exp_data));
    end
    checkOutput("o_pending", 64'(o_pending), 64'(mq.size()));
    drv_valid = drv_valid & ~accepted;
  endtask

  task automatic drain();
    int c = 0;
    while ((mq.size() != 0 || drv_valid != '0) && c < 40) begin
      applyStimulus(1'b0, acc);
      c++;
    end
    checkOutput("drain_done", 64'(mq.size() == 0 && drv_valid == '0), 64'(1));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent3;
    rst_n   = 1'b0;
    flush   = 1'b0;
    i_valid = '0;
    i_tag   = '0;
    i_data  = '0;
    for (int k = 0; k < NU; k++) begin
      drv_tag[k]  = '0;
      drv_data[k] = '0;
    end

    vecs[0]  = mk(4'b0010,  0,  5,  0,  0, 0, 0,  0, 32'h0,        4'b1111, 1);
    vecs[0].data[1*DW +: DW] = 32'hDEADBEEF;
    vecs[1]  = mk(4'b0000,  0,  0,  0,  0, 0, 1,  5, 32'hDEADBEEF, 4'b1111, 0);
    vecs[2]  = mk(4'b0000,  0,  0,  0,  0, 0, 0,  5, 32'hDEADBEEF, 4'b1111, 0);
    vecs[3]  = mk(4'b0000,  0,  0,  0,  0, 1, 0,  5, 32'hDEADBEEF, 4'b1111, 0);
    vecs[4]  = mk(4'b1111,  1,  2,  3,  4, 0, 0,  5, 32'hDEADBEEF, 4'b1111, 4);
    vecs[5]  = mk(4'b0000,  0,  0,  0,  0, 0, 1,  1, dat(1),       4'b1111, 3);
    vecs[6]  = mk(4'b0000,  0,  0,  0,  0, 0, 1,  2, dat(2),       4'b1111, 2);
    vecs[7]  = mk(4'b0000,  0,  0,  0,  0, 0, 1,  3, dat(3),       4'b1111, 1);
    vecs[8]  = mk(4'b0000,  0,  0,  0,  0, 0, 1,  4, dat(4),       4'b1111, 0);
    vecs[9]  = mk(4'b0000,  0,  0,  0,  0, 0, 0,  4, dat(4),       4'b1111, 0);
    vecs[10] = mk(4'b1010,  0,  7,  0,  8, 0, 0,  4, dat(4),       4'b1111, 2);
    vecs[11] = mk(4'b0000,  0,  0,  0,  0, 0, 1,  7, dat(7),       4'b1111, 1);
    vecs[12] = mk(4'b0000,  0,  0,  0,  0, 0, 1,  8, dat(8),       4'b1111, 0);
    vecs[13] = mk(4'b1111, 10, 11, 12, 13, 0, 0,  8, dat(8),       4'b1111, 4);
    vecs[14] = mk(4'b1111, 14, 15, 16, 17, 0, 1, 10, dat(10),      4'b0001, 7);
    vecs[15] = mk(4'b1111, 20, 15, 16, 17, 1, 0, 10, dat(10),      4'b1111, 0);
    vecs[16] = mk(4'b0000,  0,  0,  0,  0, 0, 0, 10, dat(10),      4'b1111, 0);
    vecs[17] = mk(4'b0000,  0,  0,  0,  0, 0, 0, 10, dat(10),      4'b1111, 0);

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 64'(cdb_valid), 64'(0));
    checkOutput("rst_tag", 64'(cdb_tag), 64'(0));
    checkOutput("rst_data", 64'(cdb_data), 64'(0));
    checkOutput("rst_pending", 64'(o_pending), 64'(0));
    checkOutput("rst_ready", 64'(o_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready", 64'(o_ready), 64'(4'b1111));

    for (int n = 0; n < 18; n++) begin
      flush   = vecs[n].flush;
      i_valid = vecs[n].valid;
      i_tag   = vecs[n].tag;
      i_data  = vecs[n].data;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", n), 64'(cdb_valid), 64'(vecs[n].exp_valid));
      checkOutput($sformatf("vec%0d_tag", n), 64'(cdb_tag), 64'(vecs[n].exp_tag));
      checkOutput($sformatf("vec%0d_data", n), 64'(cdb_data), 64'(vecs[n].exp_data));
      checkOutput($sformatf("vec%0d_ready", n), 64'(o_ready), 64'(vecs[n].exp_ready));
      checkOutput($sformatf("vec%0d_pending", n), 64'(o_pending), 64'(vecs[n].exp_pending));
    end

    // Unit2 streams while unit0 posts once after the pointer has moved past it.
    pushNew(0);
    applyStimulus(1'b0, acc);
    applyStimulus(1'b0, acc);
    for (int c = 0; c < 8; c++) begin
      pushNew(2);
      if (c == 1) pushNew(0);
      applyStimulus(1'b0, acc);
    end
    drain();

    // Units 0..2 saturate the bus while unit3 offers three results into a two-entry FIFO.
    applyStimulus(1'b1, acc);
    sent3 = 0;
    for (int c = 0; c < 14; c++) begin
      pushNew(0);
      pushNew(1);
      pushNew(2);
      if (!drv_valid[3] && sent3 < 3) begin
        pushNew(3);
        sent3++;
      end
      applyStimulus(1'b0, acc);
      if (c == 1) checkOutput("bp_ready3", 64'(o_ready[3]), 64'(0));
    end
    drain();

    // Five buffered results are discarded by a flush and never appear on the bus.
    applyStimulus(1'b1, acc);
    for (int k = 0; k < NU; k++) pushNew(k);
    applyStimulus(1'b0, acc);
    pushNew(0);
    pushNew(1);
    applyStimulus(1'b0, acc);
    checkOutput("flush_pre_pending", 64'(o_pending), 64'(5));
    applyStimulus(1'b1, acc);
    checkOutput("flush_valid", 64'(cdb_valid), 64'(0));
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, acc);

    // Asynchronous reset lands between edges in the middle of a burst.
    for (int k = 0; k < NU; k++) pushNew(k);
    applyStimulus(1'b0, acc);
    applyStimulus(1'b0, acc);
    checkOutput("arst_pre_valid", 64'(cdb_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(cdb_valid), 64'(0));
    checkOutput("arst_pending", 64'(o_pending), 64'(0));
    checkOutput("arst_ready", 64'(o_ready), 64'(0));
    mq.delete();
    rr        = 0;
    drv_valid = '0;
    i_valid   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, acc);

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NU; k++)
        if ($urandom_range(0, 9) < 6) pushNew(k);
      applyStimulus($urandom_range(0, 39) == 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
